gol_step_scheduler: RTL and testbench
=====================================

# gol_step_scheduler

Sequencing controller for the Game of Life generation engine: decides when the next generation is computed (free-run at a switch-selected rate, single-step, or clear), handshakes with the update engine, and commits the new board to the display only during vertical blanking so the VGA path never shows a half-updated board. It owns the generation count that drives the seven-segment display. It sits between the debounced button/switch inputs, the board update engine and the display controller.

## Interface
- TICK_BASE, 2_500_000: clk cycles per base tick (25 ms at 100 MHz); must be ≥1
- GEN_W, 16: generation counter width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- run_btn  in  1  one-cycle debounced pulse; toggles run/pause
- step_btn  in  1  one-cycle pulse; one generation when paused
- clear_btn  in  1  one-cycle pulse; clear board, zero count, pause
- speed  in  4  run period = (speed+1) base ticks
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- eng_done  in  1  one-cycle pulse from engine: requested operation finished
- eng_start  out  1  one-cycle pulse: compute next generation
- eng_clear  out  1  one-cycle pulse: clear next-board buffer
- swap  out  1  one-cycle pulse: commit next board to display buffer
- running  out  1  run mode flag
- generation  out  GEN_W  committed generation count
- state  out  3  current FSM state code (debug/LED)

## Operation
- States: IDLE=0, WAIT_TICK=1, COMPUTE=2, WAIT_VBLANK=3, SWAP=4, CLEAR=5.
- running toggles on every run_btn in any state; forced 0 on entering CLEAR.
- IDLE: clear_btn → CLEAR; else step_btn with running=0 → COMPUTE; else running=1 → WAIT_TICK.
- WAIT_TICK: prescaler counts TICK_BASE cycles per base tick; after speed+1 base ticks → COMPUTE. running=0 → IDLE. clear_btn → CLEAR. Prescaler and tick count zeroed on every entry.
- COMPUTE: wait eng_done → WAIT_VBLANK.
- CLEAR: wait eng_done → WAIT_VBLANK with clr_flag set.
- WAIT_VBLANK: frame_start → SWAP.
- SWAP (one cycle): swap pulse; generation ← 0 if clr_flag else generation+1 (wraps 2^GEN_W−1 → 0); clr_flag cleared. Next: clear_pending → CLEAR; running → WAIT_TICK; else IDLE.
- clear_btn in COMPUTE, WAIT_VBLANK or SWAP sets clear_pending; serviced after SWAP, then cleared. clear_btn in CLEAR ignored.
- step_btn outside IDLE, or while running, ignored (not queued).
- Priority in same cycle: clear > step > run tick. run_btn and clear_btn together: running ends 0.
- speed sampled each base tick; change mid-period takes effect against the current tick count (period ends as soon as count ≥ speed+1).

## Timing
- Reset: state=IDLE, running=0, generation=0, eng_start=eng_clear=swap=0, prescaler/tick count 0, clr_flag=clear_pending=0.
- All outputs registered. eng_start high exactly in the first cycle state=COMPUTE; eng_clear high exactly in the first cycle state=CLEAR; swap high exactly while state=SWAP.
- step_btn in IDLE at cycle N → eng_start at N+1.
- eng_done at cycle N → state=WAIT_VBLANK at N+1; frame_start only honoured while state=WAIT_VBLANK (a pulse coinciding with eng_done is missed; wait for next frame).
- frame_start at N → swap at N+1; generation updated at N+2.
- Running period from SWAP to next eng_start: (speed+1)·TICK_BASE+1 cycles.
- eng_done outside COMPUTE/CLEAR ignored.
- Reset asserted mid-operation: immediate return to reset values; no pulse completes.

## Test plan
- TICK_BASE=4, paused, step_btn; eng_done 5 cycles later; frame_start 10 cycles later → one eng_start, swap 1 cycle after frame_start, generation 0→1, state back to 0.
- run_btn, speed=2, engine replies eng_done after 3 cycles, frame_start immediate → eng_start every 12+1 cycles plus handshake; generation increments per swap; run_btn again stops after current swap, state=0.
- clear_btn during COMPUTE at generation 7 → swap, generation 8, then CLEAR: eng_clear pulse, second swap, generation 0, running=0.
- Preload generation=0xFFFF via steps (GEN_W=4: 15 steps then 1) → wraps to 0.
- step_btn while running, and frame_start coincident with eng_done → step ignored; swap waits for next frame_start.
- rst_n low during WAIT_VBLANK → all outputs 0 asynchronously; no swap on later frame_start.

Source files
------------

// File: rtl/gol_step_scheduler.sv
// rtl/gol_step_scheduler.sv - generation sequencing controller for the Game of Life engine
module gol_step_scheduler #(
   parameter int TICK_BASE = 2_500_000,
   parameter int GEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             clear_btn,
   input  logic [3:0]       speed,
   input  logic             frame_start,
   input  logic             eng_done,
   output logic             eng_start,
   output logic             eng_clear,
   output logic             swap,
   output logic             running,
   output logic [GEN_W-1:0] generation,
   output logic [2:0]       state
);

   localparam int PW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_TICK   = 3'd1,
      COMPUTE     = 3'd2,
      WAIT_VBLANK = 3'd3,
      SWAP        = 3'd4,
      CLEAR       = 3'd5
   } state_t;

   state_t          cur_state;
   state_t          next_state;
   logic [PW-1:0]   prescaler;
   logic [4:0]      tick_cnt;
   logic            tick_done;
   logic            clr_flag;
   logic            clear_pending;
   logic            enter_clear;

   assign state       = cur_state;
   assign tick_done   = (cur_state == WAIT_TICK) && (prescaler == PW'(TICK_BASE - 1));
   assign enter_clear = (next_state == CLEAR) && (cur_state != CLEAR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur_state <= IDLE;
      else        cur_state <= next_state;
   end

   // Next-state decision; clear beats step beats the run tick.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         IDLE: begin
            if (clear_btn)                 next_state = CLEAR;
            else if (step_btn && !running) next_state = COMPUTE;
            else if (running)              next_state = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (clear_btn)     next_state = CLEAR;
            else if (!running) next_state = IDLE;
            // count+1 >= speed+1 once this base tick completes
            else if (tick_done && (tick_cnt >= {1'b0, speed})) next_state = COMPUTE;
         end
         COMPUTE: begin
            if (eng_done) next_state = WAIT_VBLANK;
         end
         CLEAR: begin
            if (eng_done) next_state = WAIT_VBLANK;
         end
         WAIT_VBLANK: begin
            if (frame_start) next_state = SWAP;
         end
         SWAP: begin
            if (clear_pending || clear_btn) next_state = CLEAR;
            else if (running)               next_state = WAIT_TICK;
            else                            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Base-tick prescaler and tick counter, zeroed whenever not waiting for a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         tick_cnt  <= '0;
      end else if (cur_state != WAIT_TICK) begin
         prescaler <= '0;
         tick_cnt  <= '0;
      end else if (tick_done) begin
         prescaler <= '0;
         tick_cnt  <= tick_cnt + 5'd1;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Run flag: toggled by run_btn, dropped by any clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           running <= 1'b0;
      else if (enter_clear)                 running <= 1'b0;
      else if (run_btn && clear_btn)        running <= 1'b0;
      else if (run_btn)                     running <= ~running;
   end

   // Deferred clear request and the clear marker that zeroes the count at swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clear_pending <= 1'b0;
         clr_flag      <= 1'b0;
      end else begin
         if (cur_state == SWAP)
            clear_pending <= 1'b0;
         else if (clear_btn && (cur_state == COMPUTE || cur_state == WAIT_VBLANK))
            clear_pending <= 1'b1;

         if (cur_state == SWAP)
            clr_flag <= 1'b0;
         else if (cur_state == CLEAR && eng_done)
            clr_flag <= 1'b1;
      end
   end

   // Registered output pulses aligned with the first cycle of their state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_start <= 1'b0;
         eng_clear <= 1'b0;
         swap      <= 1'b0;
      end else begin
         eng_start <= (next_state == COMPUTE) && (cur_state != COMPUTE);
         eng_clear <= enter_clear;
         swap      <= (next_state == SWAP);
      end
   end

   // Committed generation count, updated as the swap cycle ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  generation <= '0;
      else if (cur_state == SWAP)  generation <= clr_flag ? '0 : generation + GEN_W'(1);
   end

endmodule

// File: tb/tb_gol_step_scheduler.sv
// tb/tb_gol_step_scheduler.sv - self-checking bench for gol_step_scheduler
module tb_gol_step_scheduler;

   localparam int TB_TICK = 4;
   localparam int GW      = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run_btn = 1'b0;
   logic          step_btn = 1'b0;
   logic          clear_btn = 1'b0;
   logic [3:0]    speed = 4'd0;
   logic          frame_start = 1'b0;
   logic          eng_done = 1'b0;
   logic          eng_start;
   logic          eng_clear;
   logic          swap;
   logic          running;
   logic [GW-1:0] generation;
   logic [2:0]    state;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model: committed count, run flag, deferred clear.
   int exp_gen     = 0;
   bit exp_running = 1'b0;
   bit exp_pend    = 1'b0;

   gol_step_scheduler #(.TICK_BASE(TB_TICK), .GEN_W(GW)) dut (
      .clk(clk), .rst_n(rst_n), .run_btn(run_btn), .step_btn(step_btn),
      .clear_btn(clear_btn), .speed(speed), .frame_start(frame_start),
      .eng_done(eng_done), .eng_start(eng_start), .eng_clear(eng_clear),
      .swap(swap), .running(running), .generation(generation), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input int budget, output int k);
      k = 0;
      while (eng_start !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk("start_seen", eng_start, 1);
   endtask

   // Paused single step request from IDLE.
   task automatic do_step();
      step_btn = 1'b1; step(); step_btn = 1'b0;
      chk("step_start", eng_start, 1);
      chk("step_state", state, 2);
      step();
      chk("start_one_cycle", eng_start, 0);
   endtask

   // Engine reply, vblank wait, swap and the post-swap state.
   task automatic finish_op(input bit is_clear, input int done_dly, input int vb_dly);
      int es;
      repeat (done_dly) step();
      eng_done = 1'b1; step(); eng_done = 1'b0;
      chk("vblank_state", state, 3);
      repeat (vb_dly) step();
      chk("no_early_swap", swap, 0);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("swap_pulse", swap, 1);
      chk("swap_state", state, 4);
      chk("gen_before", generation, exp_gen);
      step();
      exp_gen = is_clear ? 0 : (exp_gen + 1) % (1 << GW);
      chk("gen_after", generation, exp_gen);
      chk("swap_one_cycle", swap, 0);
      es = exp_pend ? 5 : (exp_running ? 1 : 0);
      chk("post_swap_state", state, es);
      if (exp_pend) begin
         chk("clear_pulse", eng_clear, 1);
         exp_pend    = 1'b0;
         exp_running = 1'b0;
      end
   endtask

   initial begin
      int k;
      int sp;

      repeat (3) step();
      chk("rst_state", state, 0);
      chk("rst_running", running, 0);
      chk("rst_gen", generation, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_clear", eng_clear, 0);
      chk("rst_swap", swap, 0);
      rst_n = 1'b1;
      step();
      chk("idle_after_rst", state, 0);

      // single step with slow engine and late frame
      do_step();
      finish_op(1'b0, 5, 10);

      // free run at random speeds
      sp = $urandom_range(0, 3);
      speed = 4'(sp);
      run_btn = 1'b1; step(); run_btn = 1'b0;
      exp_running = 1'b1;
      chk("run_on", running, 1);
      wait_start(200, k);
      chk("first_period", k, 1 + (sp + 1) * TB_TICK);
      for (int p = 0; p < 3; p++) begin
         finish_op(1'b0, 3, 0);
         sp = $urandom_range(0, 3);
         speed = 4'(sp);
         wait_start(200, k);
         chk("run_period", k, (sp + 1) * TB_TICK);
      end
      run_btn = 1'b1; step(); run_btn = 1'b0;
      exp_running = 1'b0;
      chk("run_off", running, 0);
      finish_op(1'b0, 3, 0);

      // deferred clear requested during compute at generation 7
      while (exp_gen != 7) begin
         do_step();
         finish_op(1'b0, $urandom_range(0, 4), $urandom_range(0, 3));
      end
      do_step();
      clear_btn = 1'b1; step(); clear_btn = 1'b0;
      exp_pend = 1'b1;
      chk("clear_deferred", state, 2);
      finish_op(1'b0, 2, 1);
      step();
      chk("clear_one_cycle", eng_clear, 0);
      finish_op(1'b1, 3, 2);
      chk("clear_running", running, 0);

      // counter wrap at 2^GW-1
      for (int i = 0; i < (1 << GW); i++) begin
         do_step();
         finish_op(1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      chk("wrap_zero", generation, 0);

      // steps ignored while running; frame coincident with done is missed
      speed = 4'd1;
      run_btn = 1'b1; step(); run_btn = 1'b0;
      exp_running = 1'b1;
      step_btn = 1'b1; step(); step_btn = 1'b0;
      chk("step_ignored_idle", state, 1);
      chk("step_no_start", eng_start, 0);
      step_btn = 1'b1; step(); step_btn = 1'b0;
      chk("step_ignored_tick", state, 1);
      wait_start(200, k);
      chk("period_with_steps", k, 2 * TB_TICK - 1);
      step_btn = 1'b1; step(); step_btn = 1'b0;
      chk("step_ignored_compute", eng_start, 0);
      eng_done = 1'b1; frame_start = 1'b1; step();
      eng_done = 1'b0; frame_start = 1'b0;
      chk("coincident_state", state, 3);
      chk("coincident_no_swap", swap, 0);
      repeat (3) step();
      chk("still_waiting", state, 3);
      run_btn = 1'b1; step(); run_btn = 1'b0;
      exp_running = 1'b0;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("late_swap", swap, 1);
      step();
      exp_gen = (exp_gen + 1) % (1 << GW);
      chk("late_gen", generation, exp_gen);
      chk("late_idle", state, 0);

      // asynchronous reset in WAIT_VBLANK
      do_step();
      run_btn = 1'b1; step(); run_btn = 1'b0;
      chk("run_in_compute", running, 1);
      eng_done = 1'b1; step(); eng_done = 1'b0;
      chk("pre_rst_state", state, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_running", running, 0);
      chk("arst_gen", generation, 0);
      chk("arst_swap", swap, 0);
      chk("arst_start", eng_start, 0);
      step();
      rst_n = 1'b1;
      step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("no_swap_after_rst", swap, 0);
      chk("idle_after_arst", state, 0);
      step();
      chk("gen_after_arst", generation, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
